// File: rtl/snake_field_scanner.sv
// snake_field_scanner
//
// Takes a snapshot of the packed snake-game field on request and streams the
// cells out one per transfer, in raster order (x fastest), over a valid/ready
// handshake. Per-frame statistics (snake length, apple count, invalid-code
// flag) are accumulated during the scan and published when the frame ends.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low (0 = reset)
//   field      : packed field, cell (x,y) = field[(y*SIZE_X+x)*3 +: 3]
//   frame_req  : start a scan (only honoured while idle)
//   out_ready  : downstream accepts the presented cell
//   busy       : scan or done phase in progress
//   cell_valid : cell_x/cell_y/cell_code hold a valid cell
//   cell_x     : column of presented cell
//   cell_y     : row of presented cell
//   cell_code  : code of presented cell
//   frame_done : one-cycle pulse after the last cell is accepted
//   snake_len  : cells with code 1..4 in the last completed frame
//   apple_cnt  : cells with code 5 in the last completed frame
//   bad_code   : a cell with code 6 or 7 was seen in the last completed frame
module snake_field_scanner #(
  parameter int SIZE_X     = 10,
  parameter int SIZE_Y     = 10,
  parameter int FIELD_SIZE = (SIZE_X * SIZE_Y) * 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [FIELD_SIZE-1:0]                  field,
  input  logic                                   frame_req,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   cell_valid,
  output logic [$clog2(SIZE_X)-1:0]              cell_x,
  output logic [$clog2(SIZE_Y)-1:0]              cell_y,
  output logic [2:0]                             cell_code,
  output logic                                   frame_done,
  output logic [$clog2(SIZE_X*SIZE_Y+1)-1:0]     snake_len,
  output logic [$clog2(SIZE_X*SIZE_Y+1)-1:0]     apple_cnt,
  output logic                                   bad_code
);

  localparam int XW = $clog2(SIZE_X);
  localparam int YW = $clog2(SIZE_Y);
  localparam int CW = $clog2(SIZE_X * SIZE_Y + 1);

  localparam logic [XW-1:0] X_LAST = XW'(SIZE_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SIZE_Y - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  // The snapshot is consumed as a shift register: the presented cell is
  // always the low three bits, and each transfer shifts the next cell down.
  // Raster order matches the packing order, so no index arithmetic is needed.
  logic [FIELD_SIZE-1:0] snap_q, snap_d;
  logic [CW-1:0]         snake_run_q, snake_run_d;
  logic [CW-1:0]         apple_run_q, apple_run_d;
  logic                  bad_run_q, bad_run_d;
  logic [CW-1:0]         snake_len_q, snake_len_d;
  logic [CW-1:0]         apple_cnt_q, apple_cnt_d;
  logic                  bad_code_q, bad_code_d;

  logic [2:0] cur_code;
  logic       is_snake;
  logic       is_apple;
  logic       is_bad;

  assign cur_code = snap_q[2:0];
  assign is_snake = (cur_code != 3'd0) && (cur_code <= 3'd4);
  assign is_apple = (cur_code == 3'd5);
  assign is_bad   = cur_code[2] & cur_code[1];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    snap_d      = snap_q;
    snake_run_d = snake_run_q;
    apple_run_d = apple_run_q;
    bad_run_d   = bad_run_q;
    snake_len_d = snake_len_q;
    apple_cnt_d = apple_cnt_q;
    bad_code_d  = bad_code_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_req) begin
          state_d     = ST_SCAN;
          snap_d      = field;
          x_d         = '0;
          y_d         = '0;
          snake_run_d = '0;
          apple_run_d = '0;
          bad_run_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          snap_d      = {3'b000, snap_q[FIELD_SIZE-1:3]};
          snake_run_d = snake_run_q + CW'(is_snake);
          apple_run_d = apple_run_q + CW'(is_apple);
          bad_run_d   = bad_run_q | is_bad;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              // Publish including the contribution of this final cell.
              state_d     = ST_DONE;
              snake_len_d = snake_run_d;
              apple_cnt_d = apple_run_d;
              bad_code_d  = bad_run_d;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      snap_q      <= '0;
      snake_run_q <= '0;
      apple_run_q <= '0;
      bad_run_q   <= 1'b0;
      snake_len_q <= '0;
      apple_cnt_q <= '0;
      bad_code_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      snap_q      <= snap_d;
      snake_run_q <= snake_run_d;
      apple_run_q <= apple_run_d;
      bad_run_q   <= bad_run_d;
      snake_len_q <= snake_len_d;
      apple_cnt_q <= apple_cnt_d;
      bad_code_q  <= bad_code_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign cell_valid = (state_q == ST_SCAN);
  assign frame_done = (state_q == ST_DONE);
  assign cell_x     = x_q;
  assign cell_y     = y_q;
  assign cell_code  = cur_code;
  assign snake_len  = snake_len_q;
  assign apple_cnt  = apple_cnt_q;
  assign bad_code   = bad_code_q;

endmodule
